// File: rtl/abus_pkg.sv
// -----------------------------------------------------------------------------
// abus_pkg -- shared types and constants for the Saturn A-bus initiator.
//   state_t   : transfer sequencer states
//   region_t  : decoded chip-select region (CS0/CS1/CS2 or unmapped)
//   CSn_BASE/CSn_LIMIT : inclusive byte-address windows of each region
//   OPEN_BUS  : value returned for reads that nobody answers
// -----------------------------------------------------------------------------
package abus_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD} state_t;
  typedef enum logic [1:0] {CS0, CS1, CS2, NONE} region_t;

  localparam logic [26:0] CS0_BASE  = 27'h200_0000;
  localparam logic [26:0] CS0_LIMIT = 27'h3FF_FFFF;
  localparam logic [26:0] CS1_BASE  = 27'h400_0000;
  localparam logic [26:0] CS1_LIMIT = 27'h4FF_FFFF;
  localparam logic [26:0] CS2_BASE  = 27'h580_0000;
  localparam logic [26:0] CS2_LIMIT = 27'h58F_FFFF;

  localparam logic [15:0] OPEN_BUS = 16'hFFFF;

  // Windows start even and end odd, so address bit 0 never affects the result.
  function automatic logic in_window(logic [26:0] a, logic [26:0] base, logic [26:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

  // Fixed wait length clamped into the 8-bit counter range, never below one tick.
  function automatic logic [7:0] wait_ticks(int n);
    if (n < 1)   return 8'd1;
    if (n > 255) return 8'd255;
    return 8'(n);
  endfunction

  // Active-low chip-select pattern {ACS2_N, ACS1_N, ACS0_N} for a region.
  function automatic logic [2:0] cs_n_of(region_t r);
    case (r)
      CS0:     return 3'b110;
      CS1:     return 3'b101;
      CS2:     return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/abus_if.sv
// -----------------------------------------------------------------------------
// abus_if -- Saturn A-bus signal bundle.
//   AA[25:0]  address            ADO[15:0] write data      ADI[15:0] read data
//   AFC[1:0]  function code      ACS0_N/ACS1_N/ACS2_N chip selects
//   ARD_N     read strobe        AWRL_N/AWRU_N lower/upper byte write strobes
//   AWAIT_N   responder wait request, active-low
// Modports: master (the initiator), slave (a cartridge/protection responder).
// -----------------------------------------------------------------------------
interface abus_if;
  logic [25:0] AA;
  logic [15:0] ADO;
  logic [15:0] ADI;
  logic [1:0]  AFC;
  logic        ACS0_N;
  logic        ACS1_N;
  logic        ACS2_N;
  logic        ARD_N;
  logic        AWRL_N;
  logic        AWRU_N;
  logic        AWAIT_N;

  modport master (
    output AA, ADO, AFC, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N,
    input  ADI, AWAIT_N
  );

  modport slave (
    input  AA, ADO, AFC, ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N,
    output ADI, AWAIT_N
  );
endinterface

// File: rtl/abus_region_decode.sv
// -----------------------------------------------------------------------------
// abus_region_decode -- combinational address decode.
//   addr[26:0]     : requested byte address
//   region         : CS0 / CS1 / CS2 / NONE
//   wait_len[7:0]  : fixed strobe length of that region in CE_R ticks (>= 1)
// -----------------------------------------------------------------------------
module abus_region_decode
  import abus_pkg::*;
#(
  parameter int CS0_WAIT = 4,
  parameter int CS1_WAIT = 4,
  parameter int CS2_WAIT = 2
) (
  input  logic [26:0] addr,
  output region_t     region,
  output logic [7:0]  wait_len
);

  always_comb begin
    // NOTE: both outputs get a default first so no path through this block
    // leaves them unassigned, which would otherwise infer a latch.
    region   = NONE;
    wait_len = 8'd1;
    if (in_window(addr, CS0_BASE, CS0_LIMIT)) begin
      region   = CS0;
      wait_len = wait_ticks(CS0_WAIT);
    end else if (in_window(addr, CS1_BASE, CS1_LIMIT)) begin
      region   = CS1;
      wait_len = wait_ticks(CS1_WAIT);
    end else if (in_window(addr, CS2_BASE, CS2_LIMIT)) begin
      region   = CS2;
      wait_len = wait_ticks(CS2_WAIT);
    end
  end

endmodule

// File: rtl/abus_initiator.sv
// -----------------------------------------------------------------------------
// abus_initiator -- A-bus master: turns one level-held read/write request into
// a chip-select + strobe sequence, with per-region fixed waits and AWAIT_N
// extension, and returns a one-CLK REQ_ACK.
//   CLK, RST_N (async, active-low), RES_N (sync soft reset, active-low)
//   CE_R      : bus-phase enable, every state advance waits for it
//   CE_F      : falling-phase enable, used to release strobes inside HOLD
//   REQ_A/REQ_DI/REQ_WE/REQ_RD : request (held until REQ_ACK; write wins)
//   REQ_DO/REQ_ACK/TIMEOUT     : completion
//   bus       : abus_if.master
// Optional build macro ABUS_TIMEOUT_EN: abort a transfer stuck in WAIT for
// TIMEOUT_CYC ticks (TIMEOUT_CYC exists only in that build; max 512).
// -----------------------------------------------------------------------------
module abus_initiator
  import abus_pkg::*;
#(
  parameter int CS0_WAIT = 4,
  parameter int CS1_WAIT = 4,
  parameter int CS2_WAIT = 2
`ifdef ABUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RES_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [26:0] REQ_A,
  input  logic [15:0] REQ_DI,
  input  logic [1:0]  REQ_WE,
  input  logic        REQ_RD,
  output logic [15:0] REQ_DO,
  output logic        REQ_ACK,
  output logic        TIMEOUT,
  abus_if.master      bus
);

  region_t    dec_region;
  logic [7:0] dec_wait;

  abus_region_decode #(
    .CS0_WAIT (CS0_WAIT),
    .CS1_WAIT (CS1_WAIT),
    .CS2_WAIT (CS2_WAIT)
  ) u_decode (
    .addr     (REQ_A),
    .region   (dec_region),
    .wait_len (dec_wait)
  );

  state_t      state;
  logic [2:0]  cs_n;      // {ACS2_N, ACS1_N, ACS0_N}
  logic        ard_n;
  logic        awrl_n;
  logic        awru_n;
  logic [25:0] aa;
  logic [15:0] ado;
  logic [1:0]  we;
  logic        is_wr;
  logic [7:0]  wait_len;
  logic [7:0]  cnt;       // STROBE ticks elapsed; stops at wait_len so never wraps
  logic [15:0] req_do;
  logic        req_ack;
`ifdef ABUS_TIMEOUT_EN
  localparam logic [8:0] TO_LAST = 9'(TIMEOUT_CYC - 1);
  logic [8:0]  to_cnt;    // WAIT ticks elapsed; abort fires before it could wrap
  logic        timeout_q;
`endif

  wire req_valid = REQ_RD || (|REQ_WE);

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      state <= IDLE;  cs_n <= 3'b111;  ard_n <= 1'b1;  awrl_n <= 1'b1;  awru_n <= 1'b1;
      aa <= '0;  ado <= '0;  we <= '0;  is_wr <= 1'b0;  wait_len <= 8'd1;  cnt <= '0;
      req_do <= '0;  req_ack <= 1'b0;
`ifdef ABUS_TIMEOUT_EN
      to_cnt <= '0;  timeout_q <= 1'b0;
`endif
    end else if (!RES_N) begin
      // Soft reset drops any transfer in flight without acknowledging it.
      state <= IDLE;  cs_n <= 3'b111;  ard_n <= 1'b1;  awrl_n <= 1'b1;  awru_n <= 1'b1;
      aa <= '0;  ado <= '0;  we <= '0;  is_wr <= 1'b0;  wait_len <= 8'd1;  cnt <= '0;
      req_do <= '0;  req_ack <= 1'b0;
`ifdef ABUS_TIMEOUT_EN
      to_cnt <= '0;  timeout_q <= 1'b0;
`endif
    end else begin
      req_ack <= 1'b0;
`ifdef ABUS_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // Early strobe release inside HOLD gives the responder data hold time
      // while CS stays asserted until the next CE_R.
      if (state == HOLD && CE_F) begin
        ard_n <= 1'b1;  awrl_n <= 1'b1;  awru_n <= 1'b1;
      end

      if (CE_R) begin
        unique case (state)
          IDLE: begin
            // The requester still holds its request while REQ_ACK is high;
            // refusing it then keeps one request from being served twice.
            if (req_valid && !req_ack) begin
              aa       <= REQ_A[25:0];
              ado      <= REQ_DI;
              we       <= REQ_WE;
              is_wr    <= |REQ_WE;
              wait_len <= dec_wait;
              if (dec_region == NONE) begin
                if (!(|REQ_WE)) req_do <= OPEN_BUS;
                req_ack <= 1'b1;
              end else begin
                cs_n  <= cs_n_of(dec_region);
                state <= SETUP;
              end
            end
          end
          SETUP: begin
            if (is_wr) begin
              awru_n <= ~we[1];
              awrl_n <= ~we[0];
            end else begin
              ard_n <= 1'b0;
            end
            cnt   <= 8'd1;
            state <= STROBE;
          end
          STROBE: begin
            if (cnt >= wait_len) begin
              if (bus.AWAIT_N) begin
                if (!is_wr) req_do <= bus.ADI;
                state <= HOLD;
              end else begin
`ifdef ABUS_TIMEOUT_EN
                to_cnt <= '0;
`endif
                state <= WAIT;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          WAIT: begin
            if (bus.AWAIT_N) begin
              if (!is_wr) req_do <= bus.ADI;
              state <= HOLD;
            end
`ifdef ABUS_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              cs_n  <= 3'b111;
              ard_n <= 1'b1;  awrl_n <= 1'b1;  awru_n <= 1'b1;
              if (!is_wr) req_do <= OPEN_BUS;
              req_ack   <= 1'b1;
              timeout_q <= 1'b1;
              state     <= IDLE;
            end else begin
              to_cnt <= to_cnt + 9'd1;
            end
`endif
          end
          HOLD: begin
            // Strobes are normally already released by CE_F; this covers a
            // HOLD tick that saw no CE_F.
            cs_n    <= 3'b111;
            ard_n   <= 1'b1;  awrl_n <= 1'b1;  awru_n <= 1'b1;
            req_ack <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.AA     = aa;
  assign bus.ADO    = ado;
  assign bus.AFC    = 2'b00;
  assign bus.ACS0_N = cs_n[0];
  assign bus.ACS1_N = cs_n[1];
  assign bus.ACS2_N = cs_n[2];
  assign bus.ARD_N  = ard_n;
  assign bus.AWRL_N = awrl_n;
  assign bus.AWRU_N = awru_n;
  assign REQ_DO     = req_do;
  assign REQ_ACK    = req_ack;
`ifdef ABUS_TIMEOUT_EN
  assign TIMEOUT    = timeout_q;
`else
  assign TIMEOUT    = 1'b0;
`endif

endmodule
